// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave in front of a single-port synchronous SRAM (32-bit words, 2^AW deep).
// Build option: define AHB_SRAM_ERR_RESP_EN to add the two-cycle ERROR response for bad size/alignment.
module ahb_sram_slave #(
    parameter int AW  = 12,
    parameter int DLY = 1
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic          HSEL,
    input  logic          HREADY,
    input  logic [31:0]   HADDR,
    input  logic [1:0]    HTRANS,
    input  logic [2:0]    HSIZE,
    input  logic          HWRITE,
    input  logic [31:0]   HWDATA,
    output logic          HREADYOUT,
    output logic          HRESP,
    output logic [31:0]   HRDATA,
    output logic          sram_cs,
    output logic          sram_we,
    output logic [AW-1:0] sram_addr,
    output logic [3:0]    sram_wben,
    output logic [31:0]   sram_wdata,
    input  logic [31:0]   sram_rdata,
    output logic [2:0]    fsm_state
);

`ifdef AHB_SRAM_ERR_RESP_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WDATA  = 3'd1,
        S_RDATA  = 3'd2,
        S_RSTALL = 3'd3,
        S_ERR1   = 3'd4,
        S_ERR2   = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WDATA  = 3'd1,
        S_RDATA  = 3'd2,
        S_RSTALL = 3'd3
    } state_t;
`endif

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] waddr_q;
    logic [AW-1:0] raddr_q;
    logic [2:0]    wsize_q;
    logic [1:0]    wlo_q;
    logic          hready_q;
    logic          hready_nxt;
    logic          valid;
    logic          bad_xfer;
    logic          ok_rd;
    logic          ok_wr;
    logic          unused_sig;

    // DLY only shaped the delays of a behavioural model; this RTL is zero-delay.
    assign unused_sig = ^{HADDR[31:AW+2], HTRANS[0], 1'(DLY & 1)};

    function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] lo);
        case (size)
            3'd0:    byte_en = 4'b0001 << lo;
            3'd1:    byte_en = lo[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    endfunction

    assign valid = HSEL & HREADY & HTRANS[1];

`ifdef AHB_SRAM_ERR_RESP_EN
    assign bad_xfer = valid & ((HSIZE > 3'd2) |
                               ((HSIZE == 3'd1) & HADDR[0]) |
                               ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00)));
`else
    assign bad_xfer = 1'b0;
`endif

    assign ok_rd = valid & ~bad_xfer & ~HWRITE;
    assign ok_wr = valid & ~bad_xfer & HWRITE;

    always_comb begin
        state_nxt = S_IDLE;
        case (state)
            S_RSTALL: state_nxt = S_RDATA;
`ifdef AHB_SRAM_ERR_RESP_EN
            S_ERR1:   state_nxt = S_ERR2;
`endif
            default: begin
                if (bad_xfer)
`ifdef AHB_SRAM_ERR_RESP_EN
                    state_nxt = S_ERR1;
`else
                    state_nxt = S_IDLE;
`endif
                else if (ok_wr)
                    state_nxt = S_WDATA;
                else if (ok_rd)
                    // The SRAM port is busy committing the previous write, so the read waits a cycle.
                    state_nxt = (state == S_WDATA) ? S_RSTALL : S_RDATA;
                else
                    state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        hready_nxt = (state_nxt != S_RSTALL);
`ifdef AHB_SRAM_ERR_RESP_EN
        if (state_nxt == S_ERR1)
            hready_nxt = 1'b0;
`endif
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state    <= S_IDLE;
            hready_q <= 1'b1;
            waddr_q  <= '0;
            raddr_q  <= '0;
            wsize_q  <= '0;
            wlo_q    <= '0;
        end else begin
            state    <= state_nxt;
            hready_q <= hready_nxt;
            if (state_nxt == S_WDATA) begin
                waddr_q <= HADDR[AW+1:2];
                wsize_q <= HSIZE;
                wlo_q   <= HADDR[1:0];
            end
            if (state_nxt == S_RSTALL)
                raddr_q <= HADDR[AW+1:2];
        end
    end

`ifdef AHB_SRAM_ERR_RESP_EN
    logic hresp_q;

    always_ff @(posedge HCLK) begin
        if (HRESET)
            hresp_q <= 1'b0;
        else
            hresp_q <= (state_nxt == S_ERR1) || (state_nxt == S_ERR2);
    end

    assign HRESP = hresp_q;
`else
    assign HRESP = 1'b0;
`endif

    // Strobes are gated by reset so a write pending in WDATA is dropped, not committed.
    always_comb begin
        sram_cs    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wben  = 4'b0000;
        sram_wdata = 32'h0;
        if (!HRESET) begin
            if (state == S_WDATA) begin
                sram_cs    = 1'b1;
                sram_we    = 1'b1;
                sram_addr  = waddr_q;
                sram_wben  = byte_en(wsize_q, wlo_q);
                sram_wdata = HWDATA;
            end else if (state == S_RSTALL) begin
                sram_cs   = 1'b1;
                sram_addr = raddr_q;
            end else if (ok_rd) begin
                sram_cs   = 1'b1;
                sram_addr = HADDR[AW+1:2];
            end
        end
    end

    assign HREADYOUT = hready_q;
    assign HRDATA    = (state == S_RDATA) ? sram_rdata : 32'h0;
    assign fsm_state = state;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: pipelined AHB driver, behavioural SRAM, reference memory and read-data queue.
module tb_ahb_sram_slave;
    localparam int AW = 12;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic          HSEL;
    logic          HREADY;
    logic [31:0]   HADDR;
    logic [1:0]    HTRANS;
    logic [2:0]    HSIZE;
    logic          HWRITE;
    logic [31:0]   HWDATA;
    logic          HREADYOUT;
    logic          HRESP;
    logic [31:0]   HRDATA;
    logic          sram_cs;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [3:0]    sram_wben;
    logic [31:0]   sram_wdata;
    logic [31:0]   sram_rdata = 32'h0;
    logic [2:0]    fsm_state;

    always #5 HCLK = ~HCLK;
    assign HREADY = HREADYOUT;

    ahb_sram_slave #(.AW(AW), .DLY(1)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HREADY(HREADY),
        .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
        .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wben(sram_wben),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .fsm_state(fsm_state)
    );

    // Behavioural synchronous SRAM with byte enables.
    logic [31:0] mem     [0:(1<<AW)-1] = '{default: 32'h0};
    logic [31:0] ref_mem [0:(1<<AW)-1] = '{default: 32'h0};
    int we_count = 0;

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        lane_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    always @(posedge HCLK) begin
        if (sram_cs && sram_we) begin
            mem[sram_addr] <= (mem[sram_addr] & ~lane_mask(sram_wben)) | (sram_wdata & lane_mask(sram_wben));
            we_count++;
        end else if (sram_cs) begin
            sram_rdata <= mem[sram_addr];
        end
    end

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] data;
    } txn_t;

    txn_t seq_q[$];

    function automatic logic [3:0] exp_wben(input logic [2:0] size, input logic [1:0] lo);
        if (size == 3'd0)      exp_wben = 4'b0001 << lo;
        else if (size == 3'd1) exp_wben = lo[1] ? 4'b1100 : 4'b0011;
        else                   exp_wben = 4'b1111;
    endfunction

    task automatic push_txn(input logic sel, input logic [1:0] trans, input logic wr,
                            input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data);
        txn_t t;
        t.sel = sel; t.trans = trans; t.wr = wr; t.addr = addr; t.size = size; t.data = data;
        seq_q.push_back(t);
    endtask

    task automatic push_wr(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data);
        push_txn(1'b1, 2'b10, 1'b1, addr, size, data);
    endtask

    task automatic push_rd(input logic [31:0] addr);
        push_txn(1'b1, 2'b10, 1'b0, addr, 3'd2, 32'h0);
    endtask

    task automatic push_idle();
        push_txn(1'b0, 2'b00, 1'b0, 32'h0, 3'd0, 32'h0);
    endtask

    // Entered and left at posedge+1. Drives each address phase with the previous data phase.
    task automatic run_seq();
        txn_t cur;
        txn_t prev;
        logic [31:0] exp_rd;
        logic [AW-1:0] widx;
        bit cur_rd, cur_wr, prev_rd, prev_wr;
        int waits, cur_exp_wait, prev_exp_wait;
        prev.sel = 1'b0; prev.trans = 2'b00; prev.wr = 1'b0;
        prev.addr = 32'h0; prev.size = 3'd0; prev.data = 32'h0;
        prev_exp_wait = 0;
        push_idle();
        while (seq_q.size() > 0) begin
            cur = seq_q.pop_front();
            cur_rd  = cur.sel && cur.trans[1] && !cur.wr;
            cur_wr  = cur.sel && cur.trans[1] && cur.wr;
            prev_rd = prev.sel && prev.trans[1] && !prev.wr;
            prev_wr = prev.sel && prev.trans[1] && prev.wr;
            cur_exp_wait = (cur_rd && prev_wr) ? 1 : 0;
            HSEL = cur.sel; HTRANS = cur.trans; HWRITE = cur.wr; HADDR = cur.addr; HSIZE = cur.size;
            HWDATA = prev_wr ? prev.data : 32'h0;
            widx = cur.addr[AW+1:2];
            if (cur_rd)
                exp_q.push_back(ref_mem[widx]);
            if (cur_wr)
                ref_mem[widx] = (ref_mem[widx] & ~lane_mask(exp_wben(cur.size, cur.addr[1:0])))
                              | (cur.data & lane_mask(exp_wben(cur.size, cur.addr[1:0])));
            waits = 0;
            @(negedge HCLK);
            while (HREADYOUT !== 1'b1 && waits < 4) begin
                waits++;
                @(negedge HCLK);
            end
            check("wait_states", waits, prev_exp_wait);
            check("hresp_okay", {31'h0, HRESP}, 32'h0);
            if (prev_rd) begin
                if (exp_q.size() > 0) begin
                    exp_rd = exp_q.pop_front();
                    check("read_data", HRDATA, exp_rd);
                end else begin
                    check("exp_q_underflow", 32'h1, 32'h0);
                end
            end else begin
                check("hrdata_zero", HRDATA, 32'h0);
            end
            if (prev_wr) begin
                check("write_we", {30'h0, sram_cs, sram_we}, 32'h3);
                check("write_wben", {28'h0, sram_wben}, {28'h0, exp_wben(prev.size, prev.addr[1:0])});
                check("write_addr", {20'h0, sram_addr}, {20'h0, prev.addr[AW+1:2]});
                check("write_wdata", sram_wdata, prev.data);
            end else if (cur_rd) begin
                check("read_strobe", {30'h0, sram_cs, sram_we}, 32'h2);
                check("read_addr", {20'h0, sram_addr}, {20'h0, cur.addr[AW+1:2]});
            end else begin
                check("no_sram_cs", {31'h0, sram_cs}, 32'h0);
            end
            @(posedge HCLK); #1;
            prev = cur;
            prev_exp_wait = cur_exp_wait;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int r;
        int we_before;
        logic [2:0] sz;
        logic [1:0] lo;
        logic [31:0] a;

        HRESET = 1'b1; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
        HADDR = 32'h0; HSIZE = 3'd0; HWDATA = 32'h0;
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        check("rst_hreadyout", {31'h0, HREADYOUT}, 32'h1);
        check("rst_hresp", {31'h0, HRESP}, 32'h0);
        check("rst_sram_cs", {31'h0, sram_cs}, 32'h0);
        check("rst_sram_we", {31'h0, sram_we}, 32'h0);
        check("rst_hrdata", HRDATA, 32'h0);
        @(posedge HCLK); #1;
        HRESET = 1'b0;

        // Word write then read of the same address: one wait state.
        push_wr(32'h10, 3'd2, 32'hDEADBEEF);
        push_rd(32'h10);
        run_seq();

        // Byte write into the top lane of an existing word.
        push_wr(32'h10, 3'd2, 32'h11223344);
        push_idle();
        push_wr(32'h13, 3'd0, 32'hAAAAAAAA);
        push_idle();
        push_rd(32'h10);
        run_seq();

        // Back-to-back reads with no wait states.
        push_wr(32'h20, 3'd2, 32'hCAFE0020);
        push_wr(32'h24, 3'd2, 32'hCAFE0024);
        push_idle();
        push_rd(32'h20);
        push_rd(32'h24);
        run_seq();

        // BUSY with HSEL high, and an unselected NONSEQ.
        push_txn(1'b1, 2'b01, 1'b0, 32'h20, 3'd2, 32'h0);
        push_txn(1'b1, 2'b01, 1'b1, 32'h24, 3'd2, 32'h0);
        push_txn(1'b0, 2'b10, 1'b1, 32'h20, 3'd2, 32'h12345678);
        push_rd(32'h20);
        run_seq();

        // Halfword writes in both halves, then mixed random traffic.
        push_wr(32'h30, 3'd1, 32'h5A5A5A5A);
        push_wr(32'h32, 3'd1, 32'hC3C3C3C3);
        push_rd(32'h30);
        run_seq();

        for (int i = 0; i < 80; i++) begin
            r  = $urandom_range(0, 9);
            sz = 3'($urandom_range(0, 2));
            lo = (sz == 3'd0) ? 2'($urandom_range(0, 3)) : (sz == 3'd1) ? {1'($urandom_range(0, 1)), 1'b0} : 2'b00;
            a  = 32'h100 + 32'($urandom_range(0, 15)) * 4 + {30'h0, lo};
            if (r < 2)      push_txn(1'b1, 2'($urandom_range(0, 1)), 1'b0, a, sz, 32'h0);
            else if (r < 3) push_txn(1'b0, 2'b10, 1'($urandom_range(0, 1)), a, sz, $urandom);
            else if (r < 6) push_wr(a, sz, $urandom);
            else            push_rd(a);
        end
        run_seq();

        // Reset during the write data phase drops the write.
        push_wr(32'h40, 3'd2, 32'h13579BDF);
        run_seq();
        we_before = we_count;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h40; HSIZE = 3'd2;
        @(posedge HCLK); #1;
        HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'hFFFF0000; HRESET = 1'b1;
        @(negedge HCLK);
        check("rst_wdata_we", {31'h0, sram_we}, 32'h0);
        check("rst_wdata_cs", {31'h0, sram_cs}, 32'h0);
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        @(negedge HCLK);
        check("post_rst_hreadyout", {31'h0, HREADYOUT}, 32'h1);
        check("post_rst_hresp", {31'h0, HRESP}, 32'h0);
        check("post_rst_hrdata", HRDATA, 32'h0);
        check("post_rst_we_count", we_count, we_before);
        @(posedge HCLK); #1;
        push_rd(32'h40);
        run_seq();

`ifdef AHB_SRAM_ERR_RESP_EN
        // Misaligned word read: two-cycle ERROR, no SRAM access.
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h02; HSIZE = 3'd2;
        @(negedge HCLK);
        check("err_addr_cs", {31'h0, sram_cs}, 32'h0);
        @(posedge HCLK); #1;
        HTRANS = 2'b00;
        @(negedge HCLK);
        check("err1_ready_resp", {30'h0, HREADYOUT, HRESP}, 32'h1);
        check("err1_cs", {31'h0, sram_cs}, 32'h0);
        @(posedge HCLK); #1;
        @(negedge HCLK);
        check("err2_ready_resp", {30'h0, HREADYOUT, HRESP}, 32'h3);
        check("err2_cs", {31'h0, sram_cs}, 32'h0);
        @(posedge HCLK); #1;
        @(negedge HCLK);
        check("err_done_resp", {31'h0, HRESP}, 32'h0);
        @(posedge HCLK); #1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
